// File: rtl/res_ram_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// res_ram_arb : result RAM arbiter, buffered write-back stream vs. host reads.
// Optional macro RAW_FWD_EN forwards queued write data to hazard reads. Rev 1.0
// ----------------------------------------------------------------------------
module res_ram_arb #(
  parameter int WBUF_DEPTH = 8,
  parameter int HI_WM      = 6,
  parameter int RD_MAX     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wb_we_n,
  input  logic [7:0]                  wb_addr,
  input  logic [31:0]                 wb_data,
  input  logic                        rd_req,
  input  logic [7:0]                  rd_addr,
  output logic                        rd_gnt,
  output logic                        rd_valid,
  output logic [31:0]                 rd_data,
  output logic                        ram_csn,
  output logic                        ram_wen,
  output logic [7:0]                  ram_addr,
  output logic [31:0]                 ram_wdata,
  input  logic [31:0]                 ram_rdata,
  output logic [$clog2(WBUF_DEPTH):0] wbuf_level,
  output logic                        ovf
);
  localparam int AW = $clog2(WBUF_DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = $clog2(RD_MAX + 1);
  localparam logic [LW-1:0] FULL_LVL   = LW'(WBUF_DEPTH);
  localparam logic [LW-1:0] HI_LVL     = LW'(HI_WM);
  localparam logic [SW-1:0] STREAK_MAX = SW'(RD_MAX);

  typedef enum logic [1:0] {
    GS_IDLE = 2'd0,
    GS_RD   = 2'd1,
    GS_WR   = 2'd2
  } gs_e;

  gs_e           gs_q, gs_d;
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [SW-1:0] rd_streak_q, rd_streak_d;
  logic [7:0]    ram_addr_q, ram_addr_d;
  logic [31:0]   ram_wdata_q, ram_wdata_d;
  logic          ovf_q, ovf_d;

  logic [7:0]    fifo_addr_q [WBUF_DEPTH];
  logic [31:0]   fifo_data_q [WBUF_DEPTH];

  logic [LW-1:0] level;
  logic          empty, full, push, pop, hazard;
  logic [AW-1:0] scan_idx;
  logic [7:0]    head_addr;
  logic [31:0]   head_data;

`ifdef RAW_FWD_EN
  logic [31:0]   fwd_data;
  logic [31:0]   fwd_data_q, fwd_data_d;
  logic          fwd_q, fwd_d, fwd_hit;
`endif

  // Extra pointer MSB distinguishes full from empty.
  assign level      = wr_ptr_q - rd_ptr_q;
  assign empty      = (level == '0);
  assign full       = (level == FULL_LVL);
  assign head_addr  = fifo_addr_q[rd_ptr_q[AW-1:0]];
  assign head_data  = fifo_data_q[rd_ptr_q[AW-1:0]];
  assign pop        = (gs_d == GS_WR);
  assign push       = !wb_we_n && (!full || pop);
  assign wbuf_level = level;
  assign ovf        = ovf_q;
  assign rd_valid   = (gs_q == GS_RD);

  // Only queued entries count; the same-cycle push is not yet in the array.
  always_comb begin
    hazard   = 1'b0;
    scan_idx = '0;
`ifdef RAW_FWD_EN
    fwd_data = '0;
`endif
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      scan_idx = rd_ptr_q[AW-1:0] + AW'(k);
      if ((LW'(k) < level) && (fifo_addr_q[scan_idx] == rd_addr)) begin
        hazard = 1'b1;
`ifdef RAW_FWD_EN
        fwd_data = fifo_data_q[scan_idx];
`endif
      end
    end
  end

  always_comb begin
    gs_d        = GS_IDLE;
    rd_streak_d = '0;
    ram_csn     = 1'b1;
    ram_wen     = 1'b1;
    ram_addr    = ram_addr_q;
    ram_wdata   = ram_wdata_q;
    rd_gnt      = 1'b0;
`ifdef RAW_FWD_EN
    fwd_hit     = 1'b0;
`endif
    if (!empty && ((level >= HI_LVL) || (rd_streak_q == STREAK_MAX) || full)) begin
      gs_d = GS_WR;
    end
`ifdef RAW_FWD_EN
    else if (rd_req) begin
`else
    else if (rd_req && !hazard) begin
`endif
      gs_d = GS_RD;
    end
    else if (!empty) begin
      gs_d = GS_WR;
    end

    case (gs_d)
      GS_RD: begin
        rd_gnt      = 1'b1;
        rd_streak_d = (rd_streak_q == STREAK_MAX) ? rd_streak_q : rd_streak_q + SW'(1);
`ifdef RAW_FWD_EN
        fwd_hit = hazard;
        if (!hazard) begin
`else
        begin
`endif
          ram_csn  = 1'b0;
          ram_addr = rd_addr;
        end
      end
      GS_WR: begin
        ram_csn   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = head_addr;
        ram_wdata = head_data;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q + LW'(push);
    rd_ptr_d    = rd_ptr_q + LW'(pop);
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
    ovf_d       = ovf_q | (!wb_we_n && full && !pop);
  end

`ifdef RAW_FWD_EN
  always_comb begin
    fwd_d      = fwd_hit;
    fwd_data_d = fwd_hit ? fwd_data : fwd_data_q;
  end

  assign rd_data = fwd_q ? fwd_data_q : (rd_valid ? ram_rdata : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end
`else
  assign rd_data = rd_valid ? ram_rdata : '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gs_q        <= GS_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_streak_q <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      gs_q        <= gs_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_streak_q <= rd_streak_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ovf_q       <= ovf_d;
    end
  end

  // Entry storage needs no reset: validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q[AW-1:0]] <= wb_addr;
      fifo_data_q[wr_ptr_q[AW-1:0]] <= wb_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_res_ram_arb.sv
`default_nettype none
// Bench for res_ram_arb: table-driven reads and arbitration patterns with a
// scoreboard for RAM writes and read data, plus hazard and reset sequences.
module tb_res_ram_arb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we_n;
  logic [7:0]  wb_addr;
  logic [31:0] wb_data;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic        rd_gnt, rd_valid, ram_csn, ram_wen, ovf;
  logic [31:0] rd_data, ram_wdata, ram_rdata;
  logic [7:0]  ram_addr;
  logic [3:0]  wbuf_level;

  always #5 clk = ~clk;

  res_ram_arb #(.WBUF_DEPTH(8), .HI_WM(6), .RD_MAX(4)) dut (
    .clk(clk), .rst(rst_n),
    .wb_we_n(wb_we_n), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_csn(ram_csn), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .wbuf_level(wbuf_level), .ovf(ovf)
  );

  // Single-port RAM model: read data available the cycle after the access.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (!ram_csn) begin
      if (!ram_wen) mem[ram_addr] <= ram_wdata;
      else          ram_rdata     <= mem[ram_addr];
    end
  end

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          n_wr_acc = 0;
  int          n_rd_acc = 0;
  logic [39:0] exp_wr [$];
  logic [31:0] exp_rd [$];
  logic [31:0] rd_expect;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event with no expected entry at %0t", name, $time);
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (!ram_csn && !ram_wen) n_wr_acc++;
    if (!ram_csn &&  ram_wen) n_rd_acc++;
    if (rst_n) begin
      if (rd_valid) begin
        if (exp_rd.size() == 0) fail_now("rd_valid_unexpected");
        else                    chk("sb_rd_data", rd_data, exp_rd.pop_front());
      end
      if (rd_gnt) exp_rd.push_back(rd_expect);
      if (!ram_csn && !ram_wen) begin
        if (exp_wr.size() == 0) fail_now("ram_wr_unexpected");
        else                    chk("sb_ram_wr", {ram_addr, ram_wdata}, exp_wr.pop_front());
      end
    end
  end

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] preload;
    logic [31:0] exp_data;
  } rd_vec_t;

  typedef struct {
    logic       gnt;
    logic [3:0] lvl;
  } arb_vec_t;

  task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
    wb_we_n = 1'b0;
    wb_addr = a;
    wb_data = d;
    exp_wr.push_back({a, d});
  endtask

  initial begin
    rd_vec_t  rv [5];
    arb_vec_t av [8];
    int       waited;
    int       acc0;

    rv[0] = '{8'h20, 32'h0000_CAFE, 32'h0000_CAFE};
    rv[1] = '{8'h00, 32'h1234_5678, 32'h1234_5678};
    rv[2] = '{8'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    rv[3] = '{8'h80, 32'h0000_0000, 32'h0000_0000};
    rv[4] = '{8'h5A, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
    // Reads win until 4 consecutive grants or level reaches 6.
    av[0] = '{1'b1, 4'd0}; av[1] = '{1'b1, 4'd1}; av[2] = '{1'b1, 4'd2}; av[3] = '{1'b1, 4'd3};
    av[4] = '{1'b0, 4'd4}; av[5] = '{1'b1, 4'd4}; av[6] = '{1'b1, 4'd5}; av[7] = '{1'b0, 4'd6};

    rst_n = 1'b0; wb_we_n = 1'b1; wb_addr = '0; wb_data = '0;
    rd_req = 1'b0; rd_addr = '0; rd_expect = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values and idle.
    #1;
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ram_wen", ram_wen, 1);
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_ovf", ovf, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      chk("idle_csn", ram_csn, 1);
      chk("idle_level", wbuf_level, 0);
      chk("idle_rd_valid", rd_valid, 0);
    end

    // Four-word burst, no reads.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i > 0) chk("burst_level", wbuf_level, 1);
      push_wr(8'(i), 32'(i + 1) * 32'h11);
    end
    @(posedge clk); #1;
    chk("burst_level_last", wbuf_level, 1);
    wb_we_n = 1'b1;
    @(posedge clk); #1;
    chk("burst_drained", wbuf_level, 0);
    chk("burst_sb_empty", exp_wr.size(), 0);

    // Table-driven host reads with an empty FIFO.
    for (int i = 0; i < 5; i++) begin
      mem[rv[i].addr] = rv[i].preload;
      @(posedge clk); #1;
      rd_req = 1'b1; rd_addr = rv[i].addr; rd_expect = rv[i].exp_data;
      #1;
      chk("rd_gnt", rd_gnt, 1);
      chk("rd_csn", ram_csn, 0);
      chk("rd_wen", ram_wen, 1);
      chk("rd_ram_addr", ram_addr, rv[i].addr);
      @(posedge clk); #1;
      rd_req = 1'b0;
      #1;
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, rv[i].exp_data);
    end

    // Eight writes against a continuously held read.
    mem[8'h90] = 32'h0000_9090;
    rd_expect  = 32'h0000_9090;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      push_wr(8'h40 + 8'(i), 32'hA000_0000 + 32'(i));
      rd_req = 1'b1; rd_addr = 8'h90;
      #1;
      chk("arb_gnt", rd_gnt, av[i].gnt);
      chk("arb_level", wbuf_level, av[i].lvl);
    end
    @(posedge clk); #1;
    wb_we_n = 1'b1; rd_req = 1'b0;
    #1;
    waited = 0;
    while (wbuf_level != 0 && waited < 20) begin
      @(posedge clk); #2;
      waited++;
    end
    chk("arb_drain_level", wbuf_level, 0);
    chk("arb_sb_empty", exp_wr.size(), 0);
    chk("arb_ovf", ovf, 0);

    // Read of an address whose write is still queued.
    mem[8'h07] = 32'h0000_0BAD;
    acc0 = n_rd_acc;
    @(posedge clk); #1;
    push_wr(8'h07, 32'h0000_0055);
    @(posedge clk); #1;
    wb_we_n = 1'b1; rd_req = 1'b1; rd_addr = 8'h07; rd_expect = 32'h0000_0055;
    #1;
    chk("haz_level", wbuf_level, 1);
`ifdef RAW_FWD_EN
    chk("haz_gnt_fwd", rd_gnt, 1);
    chk("haz_csn_fwd", ram_csn, 1);
`else
    chk("haz_gnt_held", rd_gnt, 0);
    chk("haz_wen_pop", ram_wen, 0);
`endif
    waited = 0;
    while (!rd_gnt && waited < 10) begin
      @(posedge clk); #2;
      waited++;
    end
    chk("haz_granted", rd_gnt, 1);
    @(posedge clk); #1;
    rd_req = 1'b0;
    #1;
    chk("haz_valid", rd_valid, 1);
    chk("haz_data", rd_data, 32'h0000_0055);
    repeat (2) @(posedge clk);
    #2;
`ifdef RAW_FWD_EN
    chk("haz_ram_reads", n_rd_acc - acc0, 0);
`else
    chk("haz_ram_reads", n_rd_acc - acc0, 1);
`endif

    // Same-cycle push and read of one address returns the pre-write data.
    mem[8'h08] = 32'h0000_1234;
    @(posedge clk); #1;
    push_wr(8'h08, 32'h0000_0077);
    rd_req = 1'b1; rd_addr = 8'h08; rd_expect = 32'h0000_1234;
    #1;
    chk("same_gnt", rd_gnt, 1);
    @(posedge clk); #1;
    wb_we_n = 1'b1; rd_req = 1'b0;
    #1;
    chk("same_data", rd_data, 32'h0000_1234);
    chk("same_wr", ram_wen, 0);
    @(posedge clk); #2;
    chk("same_mem", mem[8'h08], 32'h0000_0077);

    // Reset with five entries queued.
    rd_expect = 32'h0000_9090;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      push_wr(8'hC0 + 8'(i), 32'hC000_0000 + 32'(i));
      rd_req = 1'b1; rd_addr = 8'h90;
      #1;
      chk("prerst_gnt", rd_gnt, av[i].gnt);
    end
    @(posedge clk); #1;
    chk("prerst_level", wbuf_level, 5);
    wb_we_n = 1'b1; rd_req = 1'b0;
    rst_n = 1'b0;
    exp_wr.delete();
    exp_rd.delete();
    acc0 = n_wr_acc;
    #1;
    chk("rst_level_now", wbuf_level, 0);
    chk("rst_csn_now", ram_csn, 1);
    chk("rst_ovf_now", ovf, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("rst_no_writes", n_wr_acc - acc0, 0);
    chk("rst_level_after", wbuf_level, 0);
    chk("rst_ovf_after", ovf, 0);
    chk("final_rd_sb_empty", exp_rd.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
